// File: rtl/mu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MU_op encodings,
// default operation latencies and the unit's state encoding.
package mu_pkg;

  localparam logic [3:0] MU_MULT  = 4'd0;
  localparam logic [3:0] MU_MULTU = 4'd1;
  localparam logic [3:0] MU_DIV   = 4'd2;
  localparam logic [3:0] MU_DIVU  = 4'd3;
  localparam logic [3:0] MU_MTHI  = 4'd4;
  localparam logic [3:0] MU_MTLO  = 4'd5;
  localparam logic [3:0] MU_MFHI  = 4'd6;
  localparam logic [3:0] MU_MFLO  = 4'd7;
  localparam logic [3:0] MU_NONE  = 4'd8;

  localparam int MU_MULT_CYCLES = 5;
  localparam int MU_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mu_state_t;

endpackage

// File: rtl/mu_calc.sv
// Combinational arithmetic core: produces the full {hi,lo} result for
// mult/multu/div/divu, plus a flag marking a divide by zero.
module mu_calc
  import mu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               div0
);

  logic signed [2*WIDTH-1:0] a_sx;
  logic signed [2*WIDTH-1:0] b_sx;
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      is_div;
  logic                      neg_a;
  logic                      neg_b;
  logic        [WIDTH-1:0]   mag_a;
  logic        [WIDTH-1:0]   mag_b;
  logic        [WIDTH-1:0]   divisor;
  logic        [WIDTH-1:0]   q_u;
  logic        [WIDTH-1:0]   r_u;
  logic        [WIDTH-1:0]   quot;
  logic        [WIDTH-1:0]   rem;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed divide runs on magnitudes so the -2^(W-1) / -1 case wraps
  // cleanly instead of relying on simulator-specific overflow behaviour.
  assign is_div  = (op == MU_DIV);
  assign neg_a   = is_div && a[WIDTH-1];
  assign neg_b   = is_div && b[WIDTH-1];
  assign mag_a   = neg_a ? (~a + WIDTH'(1)) : a;
  assign mag_b   = neg_b ? (~b + WIDTH'(1)) : b;
  assign div0    = (b == '0) && ((op == MU_DIV) || (op == MU_DIVU));
  assign divisor = (b == '0) ? WIDTH'(1) : mag_b;
  assign q_u     = mag_a / divisor;
  assign r_u     = mag_a % divisor;
  assign quot    = (neg_a ^ neg_b) ? (~q_u + WIDTH'(1)) : q_u;
  assign rem     = neg_a ? (~r_u + WIDTH'(1)) : r_u;

  always_comb begin
    result = '0;
    case (op)
      MU_MULT:          result = $unsigned(prod_s);
      MU_MULTU:         result = prod_u;
      MU_DIV, MU_DIVU:  result = {rem, quot};
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed-latency mult/div,
// reports busy to the stall unit and serves mfhi/mflo reads.
module mult_div_unit
  import mu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mu_op,
  input  logic             req,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] mu_result
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mu_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi_pend;
  logic [WIDTH-1:0]   lo_pend;
  logic               div0_pend;
  logic [2*WIDTH-1:0] calc_res;
  logic               calc_div0;
  logic               is_md;
  logic               is_mult;

  mu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (mu_op),
    .a      (src_a),
    .b      (src_b),
    .result (calc_res),
    .div0   (calc_div0)
  );

  assign is_mult = (mu_op == MU_MULT) || (mu_op == MU_MULTU);
  assign is_md   = is_mult || (mu_op == MU_DIV) || (mu_op == MU_DIVU);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      hi_pend   <= '0;
      lo_pend   <= '0;
      div0_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!req) begin
            if (start && is_md) begin
              hi_pend   <= calc_res[2*WIDTH-1:WIDTH];
              lo_pend   <= calc_res[WIDTH-1:0];
              div0_pend <= calc_div0;
              cnt       <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              busy      <= 1'b1;
              state     <= ST_RUN;
            end else if (mu_op == MU_MTHI) begin
              hi <= src_a;
            end else if (mu_op == MU_MTLO) begin
              lo <= src_a;
            end
          end
        end
        // Requests arriving here are illegal and ignored; req cannot cancel.
        ST_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (!div0_pend) begin
              hi <= hi_pend;
              lo <= lo_pend;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mu_result = '0;
    if (mu_op == MU_MFHI)      mu_result = hi;
    else if (mu_op == MU_MFLO) mu_result = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy length are
// queued when an operation is issued and compared when it completes.
module tb_mult_div_unit;
  import mu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mu_op;
  logic        req;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] mu_result;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  int          errors = 0;
  int          checks = 0;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mu_op     (mu_op),
    .req       (req),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .mu_result (mu_result)
  );

  always #5 clk = ~clk;

  // Stall contract: no MU side-effect request may reach E while busy.
  always @(posedge clk) begin
    if (!reset && busy === 1'b1)
      assert (!(start === 1'b1 || mu_op == MU_MTHI || mu_op == MU_MTLO))
        else $error("illegal MU request while busy");
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b);
    longint      sq, sr;
    logic [63:0] p;
    case (op)
      MU_MULT: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        p  = sq;
      end
      MU_MULTU: p = {32'd0, a} * {32'd0, b};
      MU_DIV: begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        p  = {sr[31:0], sq[31:0]};
      end
      default: p = {a % b, a / b};
    endcase
    return p;
  endfunction

  // Drive one E-stage cycle starting just after a falling edge.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, b,
                       input logic st, input logic rq);
    exp_t        e;
    logic [63:0] r;
    mu_op = op; start = st; src_a = a; src_b = b; req = rq;
    if (!rq && busy !== 1'b1) begin
      if (st && op <= MU_DIVU) begin
        e.cycles = (op <= MU_MULTU) ? 5 : 10;
        if (op >= MU_DIV && b == 32'd0) begin
          e.hi = hi_m; e.lo = lo_m;
        end else begin
          r = model(op, a, b);
          e.hi = r[63:32]; e.lo = r[31:0];
        end
        hi_m = e.hi; lo_m = e.lo;
        sb.push_back(e);
      end else if (op == MU_MTHI) hi_m = a;
      else if (op == MU_MTLO) lo_m = a;
    end
    @(negedge clk);
    start = 1'b0; mu_op = MU_NONE; req = 1'b0; src_a = '0; src_b = '0;
  endtask

  task automatic wait_done(input int req_at, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      req = (cyc == req_at);
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, lo);
    mu_op = MU_MFHI; #1 hi = mu_result;
    mu_op = MU_MFLO; #1 lo = mu_result;
    mu_op = MU_NONE; #1;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (h !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", h); end
    checks++; if (l !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", l); end
  endtask

  task automatic test_mult;
    exp_t e; int cyc; logic [31:0] h, l;
    drive(MU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    wait_done(0, cyc);
    e = sb.pop_front();
    read_hilo(h, l);
    checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL mult_busy: got %0d want %0d", cyc, e.cycles); end
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", h); end
    checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", l); end
  endtask

  task automatic test_div;
    exp_t e; int cyc; logic [31:0] h, l;
    drive(MU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    wait_done(0, cyc);
    e = sb.pop_front();
    read_hilo(h, l);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL div_busy: got %0d want 10", cyc); end
    checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", l); end
    checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", h); end
    drive(MU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(0, cyc);
    e = sb.pop_front();
    read_hilo(h, l);
    checks++; if (l !== 32'h8000_0000 || l !== e.lo) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", l); end
    checks++; if (h !== 32'd0 || h !== e.hi) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", h); end
  endtask

  task automatic test_divu_div0;
    exp_t e; int cyc; logic [31:0] h, l;
    drive(MU_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b1, 1'b0);
    wait_done(0, cyc);
    e = sb.pop_front();
    read_hilo(h, l);
    checks++; if (l !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_lo: got %h want 0fffffff", l); end
    checks++; if (h !== 32'hF) begin errors++; $display("FAIL divu_hi: got %h want f", h); end
    drive(MU_DIV, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    wait_done(0, cyc);
    e = sb.pop_front();
    read_hilo(h, l);
    checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL div0_busy: got %0d want %0d", cyc, e.cycles); end
    checks++; if (h !== 32'hF || l !== 32'h0FFF_FFFF) begin errors++; $display("FAIL div0_hilo: got %h_%h want 0000000f_0fffffff", h, l); end
  endtask

  task automatic test_move;
    logic [31:0] h, l;
    drive(MU_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    drive(MU_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
    read_hilo(h, l);
    checks++; if (h !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h want 12345678", h); end
    checks++; if (l !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo: got %h want 9abcdef0", l); end
    #1;
    checks++; if (mu_result !== 32'd0) begin errors++; $display("FAIL result_none: got %h want 0", mu_result); end
    drive(MU_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1);
    read_hilo(h, l);
    checks++; if (l !== lo_m) begin errors++; $display("FAIL mtlo_req: got %h want %h", l, lo_m); end
    drive(MU_MFHI, 32'd5, 32'd7, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_op_start: busy got %b want 0", busy); end
  endtask

  task automatic test_flush;
    exp_t e; int cyc; logic [31:0] h, l;
    drive(MU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    repeat (3) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
      @(negedge clk);
    end
    read_hilo(h, l);
    checks++; if (h !== hi_m || l !== lo_m) begin errors++; $display("FAIL flush_hilo: got %h_%h want %h_%h", h, l, hi_m, lo_m); end
    drive(MU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(3, cyc);
    e = sb.pop_front();
    read_hilo(h, l);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL inflight_busy: got %0d want 5", cyc); end
    checks++; if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin errors++; $display("FAIL inflight_hilo: got %h_%h want fffffffe_00000001", h, l); end
  endtask

  task automatic test_back_to_back;
    exp_t e; int cyc; logic [31:0] h, l, a, b; logic [3:0] op;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 3));
      a  = $urandom();
      b  = (i == 5) ? 32'd0 : $urandom();
      drive(op, a, b, 1'b1, 1'b0);
      wait_done(0, cyc);
      if (sb.size() == 0) begin
        checks++; errors++; $display("FAIL b2b_queue: got empty want entry");
      end else begin
        e = sb.pop_front();
        read_hilo(h, l);
        checks++; if (cyc !== e.cycles) begin errors++; $display("FAIL b2b_busy op=%0d: got %0d want %0d", op, cyc, e.cycles); end
        checks++; if (h !== e.hi || l !== e.lo) begin errors++; $display("FAIL b2b_hilo op=%0d a=%h b=%h: got %h_%h want %h_%h", op, a, b, h, l, e.hi, e.lo); end
      end
    end
  endtask

  task automatic test_reset_run;
    logic [31:0] h, l;
    drive(MU_MULT, 32'd7, 32'd9, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    hi_m = '0; lo_m = '0;
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b want 0", busy); end
    checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL rst_run_hilo: got %h_%h want 0_0", h, l); end
    repeat (8) @(negedge clk);
    read_hilo(h, l);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_late_busy: got %b want 0", busy); end
    checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL rst_late_hilo: got %h_%h want 0_0", h, l); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mu_op = MU_NONE; req = 1'b0;
    src_a = '0; src_b = '0; hi_m = '0; lo_m = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_divu_div0();
    test_move();
    test_flush();
    test_back_to_back();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit of the P7 pipeline.
- Consumes the MU_op/Start decode produced for the instruction in E, together with the forwarded rs/rt operands.
- Owns the architectural HI/LO registers.
- Provides busy to the stall unit and returns HI/LO to the E-stage result mux for mfhi/mflo.
- Models fixed-latency multicycle mult/multu (5 cycles) and div/divu (10 cycles).

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy duration for mult/multu.
- DIV_CYCLES, 10, busy duration for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is mult/multu/div/divu.
- mu_op  input  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo, 8 none.
- req  input  1  exception/interrupt flush this cycle; blocks any HI/LO side effect of the E instruction.
- src_a  input  WIDTH  forwarded rs value.
- src_b  input  WIDTH  forwarded rt value.
- busy  output  1  multicycle operation in progress.
- mu_result  output  WIDTH  HI for mfhi, LO for mflo, 0 otherwise.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it is sampled on the rising edge of clk.
- Reset values: HI=0, LO=0, busy=0, counter=0, state=IDLE, pending HI/LO temporaries=0.
- Reset mid-operation aborts the operation. HI/LO are cleared and not updated.
- States:
  - IDLE.
  - RUN (counter > 0).
- IDLE -> RUN: all of the following hold at the edge:
  - start=1, req=0, and mu_op is 0..3.
  - Unit latches the full 64-bit result into temporaries.
  - counter loads MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - busy=1 from the next cycle.
- RUN:
  - counter decrements each edge.
  - On the edge where counter goes 1->0, HI/LO take the temporaries, busy falls to 0, and state returns to IDLE.
  - busy is therefore high for exactly N cycles.
  - HI/LO are readable with new values on the first cycle busy=0.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (src_b=0, div or divu): unit still goes busy for DIV_CYCLES; HI/LO are left unchanged at completion.
- mthi/mtlo:
  - When mu_op=4/5, in IDLE, with req=0: HI/LO <= src_a at the edge. Visible next cycle.
  - No busy assertion.
- Read path: mu_result is combinational from the architectural HI/LO, with no forwarding of pending temporaries.
- req=1 suppresses start, mthi and mtlo in the same cycle. An operation already in RUN is unaffected by req and completes.
- start, mthi or mtlo arriving while busy=1 (illegal; the stall unit holds such instructions in D): ignored, and no state changes. The bench flags this with an assertion.
- start with mu_op outside 0..3: ignored.
- Stall contract: the stall unit stalls D when the D instruction is an MU instruction and either busy=1 or start=1 in E.

Decomposition:
- Shared package mu_pkg holds:
  - MU_op constants (MU_mult..MU_none, 4-bit).
  - MULT/DIV cycle counts.
  - The state encoding.
  - The same MU_op encodings are used by the control decoder.
- One natural sub-module: mu_calc. It is purely combinational; it takes op, a and b and returns a 64-bit {hi,lo} result plus a div0 flag.
- mult_div_unit holds the counter, FSM and HI/LO registers.

Test Plan:
- Signed multiply:
  - Stimulus: reset, then mult with src_a=0xFFFFFFFE (-2), src_b=3.
  - Response: busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi/mflo return these values.
- Signed divide:
  - Stimulus: div with src_a=0xFFFFFFF9 (-7), src_b=2.
  - Response: busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- Unsigned divide, then divide by zero:
  - Stimulus: divu 0xFFFFFFFF/16, then div by 0.
  - Response: after the first, LO=0x0FFFFFFF, HI=0xF. The second holds busy 10 cycles and leaves HI/LO unchanged.
- Move-to and exception suppression:
  - Stimulus: mthi 0x12345678 then mtlo 0x9ABCDEF0 on back-to-back cycles.
  - Response: mfhi/mflo read those values.
  - Stimulus: mtlo with req=1.
  - Response: LO unchanged.
- Flush versus in-flight operation:
  - Stimulus: multu 0xFFFFFFFF*0xFFFFFFFF with req=1 on the start cycle.
  - Response: busy stays 0; HI/LO unchanged.
  - Stimulus: repeat with req=0, then pulse req mid-RUN.
  - Response: completes with HI=0xFFFFFFFE, LO=0x00000001.
- Reset during RUN:
  - Stimulus: start mult, assert reset on the 3rd busy cycle.
  - Response: next cycle busy=0, HI=LO=0, and no late update afterwards.
